// File: rtl/hci_core_cut_if.sv
// hci_core_intf: one HCI-Core link; the target modport faces upstream, the initiator modport faces downstream.
interface hci_core_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned BW = DW / 8,
    parameter int unsigned UW = 2
) ();
    logic          req;
    logic          gnt;
    logic [AW-1:0] add;
    logic          wen;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [UW-1:0] user;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_opc;
    logic [UW-1:0] r_user;
    logic          lrdy;
    modport target (
        input  req, add, wen, data, be, user, lrdy,
        output gnt, r_valid, r_data, r_opc, r_user
    );
    modport initiator (
        output req, add, wen, data, be, user, lrdy,
        input  gnt, r_valid, r_data, r_opc, r_user
    );
endinterface

// File: rtl/hci_core_cut.sv
// hci_core_cut: timing cut for an HCI-Core link, 2-entry request skid buffer and 1-stage response register.
// Define HCI_CORE_CUT_PERF_EN to add the accepted-request and stall-cycle counters.
module hci_core_cut #(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned BW          = DW / 8,
    parameter int unsigned UW          = 2,
    parameter bit          BYPASS_REQ  = 1'b0,
    parameter bit          BYPASS_RESP = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    hci_core_intf.target    tcdm_target,
    hci_core_intf.initiator tcdm_initiator
`ifdef HCI_CORE_CUT_PERF_EN
    ,
    output logic [31:0]     perf_req_o,
    output logic [31:0]     perf_stall_o
`endif
);
    localparam int unsigned EW = AW + 1 + DW + BW + UW;
    logic push;
    assign push = tcdm_target.req & tcdm_target.gnt;
    if (BYPASS_REQ) begin : g_req_bypass
        assign tcdm_initiator.req  = tcdm_target.req;
        assign tcdm_initiator.add  = tcdm_target.add;
        assign tcdm_initiator.wen  = tcdm_target.wen;
        assign tcdm_initiator.data = tcdm_target.data;
        assign tcdm_initiator.be   = tcdm_target.be;
        assign tcdm_initiator.user = tcdm_target.user;
        assign tcdm_target.gnt     = tcdm_initiator.gnt;
    end else begin : g_req_skid
        logic [1:0]         cnt_q, cnt_d;
        logic               wr_q, wr_d, rd_q, rd_d, pop;
        logic [1:0][EW-1:0] buf_q, buf_d;
        // gnt depends only on occupancy so the downstream gnt path is cut
        assign tcdm_target.gnt    = cnt_q != 2'd2;
        assign tcdm_initiator.req = cnt_q != 2'd0;
        assign pop                = tcdm_initiator.req & tcdm_initiator.gnt;
        assign {tcdm_initiator.add, tcdm_initiator.wen, tcdm_initiator.data,
                tcdm_initiator.be, tcdm_initiator.user} = buf_q[rd_q];
        always_comb begin
            buf_d = buf_q;
            if (push) buf_d[wr_q] = {tcdm_target.add, tcdm_target.wen, tcdm_target.data,
                                     tcdm_target.be, tcdm_target.user};
            cnt_d = clear_i ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
            wr_d  = ~clear_i & (wr_q ^ push);
            rd_d  = ~clear_i & (rd_q ^ pop);
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= 2'd0;
                wr_q  <= 1'b0;
                rd_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                wr_q  <= wr_d;
                rd_q  <= rd_d;
            end
        end
        always_ff @(posedge clk_i) buf_q <= buf_d;
    end
    if (BYPASS_RESP) begin : g_resp_bypass
        assign tcdm_target.r_valid = tcdm_initiator.r_valid;
        assign tcdm_target.r_data  = tcdm_initiator.r_data;
        assign tcdm_target.r_opc   = tcdm_initiator.r_opc;
        assign tcdm_target.r_user  = tcdm_initiator.r_user;
        assign tcdm_initiator.lrdy = tcdm_target.lrdy;
    end else begin : g_resp_reg
        logic          r_valid_q, r_valid_d, r_opc_q, r_opc_d, load, cap;
        logic [DW-1:0] r_data_q, r_data_d;
        logic [UW-1:0] r_user_q, r_user_d;
        assign load                = ~r_valid_q | tcdm_target.lrdy;
        assign cap                 = load & tcdm_initiator.r_valid;
        assign tcdm_initiator.lrdy = load;
        assign tcdm_target.r_valid = r_valid_q;
        assign tcdm_target.r_data  = r_data_q;
        assign tcdm_target.r_opc   = r_opc_q;
        assign tcdm_target.r_user  = r_user_q;
        always_comb begin
            r_valid_d = ~clear_i & (load ? tcdm_initiator.r_valid : r_valid_q);
            r_data_d  = clear_i ? '0 : cap ? tcdm_initiator.r_data : r_data_q;
            r_opc_d   = ~clear_i & (cap ? tcdm_initiator.r_opc : r_opc_q);
            r_user_d  = clear_i ? '0 : cap ? tcdm_initiator.r_user : r_user_q;
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
                r_opc_q   <= 1'b0;
                r_user_q  <= '0;
            end else begin
                r_valid_q <= r_valid_d;
                r_data_q  <= r_data_d;
                r_opc_q   <= r_opc_d;
                r_user_q  <= r_user_d;
            end
        end
    end
`ifdef HCI_CORE_CUT_PERF_EN
    logic [31:0] perf_req_q, perf_req_d, perf_stall_q, perf_stall_d;
    always_comb begin
        perf_req_d   = clear_i ? 32'd0 : perf_req_q + {31'd0, push};
        perf_stall_d = clear_i ? 32'd0 : perf_stall_q + {31'd0, tcdm_target.req & ~tcdm_target.gnt};
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_req_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_req_q   <= perf_req_d;
            perf_stall_q <= perf_stall_d;
        end
    end
    assign perf_req_o   = perf_req_q;
    assign perf_stall_o = perf_stall_q;
`endif
endmodule
